// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and default sizing.
// MAX_HOLD default only exists when ARB_TIMEOUT_EN is defined.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned ARB_N     = 8;
    localparam int unsigned ARB_IDX_W = $clog2(ARB_N);
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned ARB_MAX_HOLD = 16;
`endif

endpackage

// File: rtl/rr_pick_enc.sv
// Combinational round-robin pick: first set request after last_idx, scanning upward mod N.
module rr_pick_enc #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_idx_i,
    output logic [IDX_W-1:0] pick_idx_o,
    output logic             pick_valid_o
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic             found;

    always_comb begin
        rot   = '0;
        off   = '0;
        found = 1'b0;
        // Rotate so that bit 0 is the requester just after the previous owner.
        for (int i = 0; i < int'(N); i++) begin
            rot[i] = req_i[IDX_W'(i) + last_idx_i + IDX_W'(1)];
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = IDX_W'(i);
            end
        end
        pick_idx_o   = off + last_idx_i + IDX_W'(1);
        pick_valid_o = |req_i;
    end

endmodule

// File: rtl/rr_arbiter8_enc.sv
// Round-robin arbiter for N requesters with one-hot grant and encoded index.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8_enc
    import arb_pkg::*;
#(
    parameter int unsigned N     = ARB_N,
    parameter int unsigned IDX_W = ARB_IDX_W
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o
);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             owner_req;

    rr_pick_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i        (req_i),
        .last_idx_i   (last_q),
        .pick_idx_o   (pick_idx),
        .pick_valid_o (pick_valid)
    );

    // Index is encoded from the registered grant so gnt and gnt_idx can never disagree.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt_q[i]) begin
                gnt_idx = gnt_idx | IDX_W'(i);
            end
        end
    end

    assign owner_req = |(req_i & gnt_q);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    state_d         = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    gnt_d   = '0;
                    last_d  = gnt_idx;
                    state_d = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    gnt_d     = '0;
                    last_d    = gnt_idx;
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(N - 1);
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx;
    assign gnt_valid_o = |gnt_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8_enc.sv
// Directed bench for rr_arbiter8_enc: vector table plus hand sequences for reset and hold limit.
// Hold-limit expectations follow ARB_TIMEOUT_EN.
module tb_rr_arbiter8_enc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
    } vec_t;

    vec_t tbl[$];

    rr_arbiter8_enc dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_out(input string name, input logic [7:0] g, input logic [2:0] i,
                           input logic v);
        chk({name, ".gnt"}, 32'(gnt), 32'(g));
        chk({name, ".idx"}, 32'(gnt_idx), 32'(i));
        chk({name, ".vld"}, 32'(gnt_valid), 32'(v));
    endtask

    // Grant/index/valid consistency on every cycle.
    always @(negedge clk) begin
        logic [7:0] exp_g;
        exp_g = {7'b0, gnt_valid} << gnt_idx;
        chk("consist.gnt", 32'(gnt), 32'(exp_g));
        if (!gnt_valid) chk("consist.idx0", 32'(gnt_idx), 32'd0);
    end

    initial begin
        logic [7:0] b;

        // Reset state and single requester.
        do_reset();
        #1;
        chk_out("reset", 8'h00, 3'd0, 1'b0);
        chk("reset.timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        req = 8'h01;
        tick();
        chk_out("t1.grant", 8'h01, 3'd0, 1'b1);
        req = 8'h00;
        tick();
        chk_out("t1.release", 8'h00, 3'd0, 1'b0);

        // Rotation through all requesters, wrap, and no preemption.
        for (int k = 0; k <= 8; k++) begin
            b = 8'h01 << (k % 8);
            tbl.push_back('{req: 8'hFF, gnt: b, idx: 3'(k % 8), vld: 1'b1});
            tbl.push_back('{req: 8'hFF & ~b, gnt: 8'h00, idx: 3'd0, vld: 1'b0});
        end
        tbl.push_back('{req: 8'h81, gnt: 8'h80, idx: 3'd7, vld: 1'b1});
        tbl.push_back('{req: 8'h01, gnt: 8'h00, idx: 3'd0, vld: 1'b0});
        tbl.push_back('{req: 8'h81, gnt: 8'h01, idx: 3'd0, vld: 1'b1});
        tbl.push_back('{req: 8'h80, gnt: 8'h00, idx: 3'd0, vld: 1'b0});
        tbl.push_back('{req: 8'h00, gnt: 8'h00, idx: 3'd0, vld: 1'b0});
        tbl.push_back('{req: 8'h04, gnt: 8'h04, idx: 3'd2, vld: 1'b1});
        tbl.push_back('{req: 8'h26, gnt: 8'h04, idx: 3'd2, vld: 1'b1});
        tbl.push_back('{req: 8'h26, gnt: 8'h04, idx: 3'd2, vld: 1'b1});
        tbl.push_back('{req: 8'h22, gnt: 8'h00, idx: 3'd0, vld: 1'b0});
        tbl.push_back('{req: 8'h22, gnt: 8'h20, idx: 3'd5, vld: 1'b1});
        tbl.push_back('{req: 8'h02, gnt: 8'h00, idx: 3'd0, vld: 1'b0});
        tbl.push_back('{req: 8'h02, gnt: 8'h02, idx: 3'd1, vld: 1'b1});
        tbl.push_back('{req: 8'h00, gnt: 8'h00, idx: 3'd0, vld: 1'b0});

        do_reset();
        for (int v = 0; v < tbl.size(); v++) begin
            req = tbl[v].req;
            tick();
            chk_out($sformatf("tbl[%0d]", v), tbl[v].gnt, tbl[v].idx, tbl[v].vld);
            chk($sformatf("tbl[%0d].timeout", v), 32'(timeout), 32'd0);
        end

        // Asynchronous reset in the middle of a grant.
        req = 8'h01;
        tick();
        chk_out("t5.pre", 8'h01, 3'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t5.async", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        req   = 8'h80;
        rst_n = 1'b1;
        tick();
        chk_out("t5.after", 8'h80, 3'd7, 1'b1);
        req = 8'h00;
        tick();
        chk_out("t5.release", 8'h00, 3'd0, 1'b0);

        // Owner that never releases.
        do_reset();
        req = 8'h09;
        tick();
        chk_out("t6.first", 8'h01, 3'd0, 1'b1);
        for (int c = 1; c < 16; c++) begin
            tick();
            chk_out($sformatf("t6.hold%0d", c), 8'h01, 3'd0, 1'b1);
            chk($sformatf("t6.hold%0d.timeout", c), 32'(timeout), 32'd0);
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        chk_out("t6.forced", 8'h00, 3'd0, 1'b0);
        chk("t6.timeout", 32'(timeout), 32'd1);
        tick();
        chk_out("t6.next", 8'h08, 3'd3, 1'b1);
        chk("t6.next.timeout", 32'(timeout), 32'd0);
`else
        chk_out("t6.kept", 8'h01, 3'd0, 1'b1);
        chk("t6.timeout", 32'(timeout), 32'd0);
        for (int c = 0; c < 8; c++) tick();
        chk_out("t6.still", 8'h01, 3'd0, 1'b1);
`endif
        req = 8'h00;
        tick();
        chk_out("t6.end", 8'h00, 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
